// File: rtl/fft_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_sequencer
// Purpose  : Frame-level controller for the axi_fft datapath. A host start
//            runs one complete FFT frame: launch the input loader, wait for
//            the core to start streaming, supervise output capture through
//            the receiving flag, then report completion. Also provides the
//            output-buffer read lock, an NFFT length check, a watchdog and a
//            completed-frame counter.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk            in   1      clock
//   resetn         in   1      synchronous active-low reset
//   start          in   1      one-cycle start pulse (accepted in IDLE only)
//   abort          in   1      one-cycle abort pulse (ignored in IDLE)
//   ack            in   1      host acknowledge, clears done
//   timeout_cycles in   32     watchdog limit in cycles, 0 disables it
//   in_load_start  out  1      one-cycle pulse launching the input loader
//   in_load_done   in   1      input loader finished pushing NFFT samples
//   out_receiving  in   1      receiving flag from the output capture block
//   busy           out  1      high in every state except IDLE
//   buf_lock       out  1      high in WAIT_OUT and CAPTURE
//   done           out  1      sticky frame-complete flag
//   irq            out  1      one-cycle pulse on completion or error
//   err_timeout    out  1      sticky watchdog-expired flag
//   err_len        out  1      sticky capture-length-mismatch flag
//   frame_count    out  CNT_W  completed frames, wraps
// ============================================================================
module fft_frame_sequencer #(
  parameter int NFFT  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             abort,
  input  logic             ack,
  input  logic [31:0]      timeout_cycles,
  output logic             in_load_start,
  input  logic             in_load_done,
  input  logic             out_receiving,
  output logic             busy,
  output logic             buf_lock,
  output logic             done,
  output logic             irq,
  output logic             err_timeout,
  output logic             err_len,
  output logic [CNT_W-1:0] frame_count
);

  // Two spare bits above clog2(NFFT) let over-long captures be told apart
  // from exact ones before the counter saturates.
  localparam int LEN_W = $clog2(NFFT) + 2;

  localparam logic [LEN_W-1:0] c_len_max  = '1;
  localparam logic [LEN_W-1:0] c_len_nfft = LEN_W'(NFFT);

  localparam logic [2:0] c_idle     = 3'd0;
  localparam logic [2:0] c_load     = 3'd1;
  localparam logic [2:0] c_wait_out = 3'd2;
  localparam logic [2:0] c_capture  = 3'd3;
  localparam logic [2:0] c_done     = 3'd4;
  localparam logic [2:0] c_error    = 3'd5;

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic             r_rx_prev;
  logic [LEN_W-1:0] r_len;
  logic [31:0]      r_wd;

  logic w_accept;
  logic w_abort;
  logic w_wd_hit;
  logic w_rise;
  logic w_fall;
  logic w_done_set;
  logic w_err_set;

  // A new frame is only accepted from IDLE; abort only matters outside it.
  assign w_accept = (r_state == c_idle) && start;
  assign w_abort  = (r_state != c_idle) && abort;

  // Watchdog expiry; only consulted in the supervised states.
  assign w_wd_hit = (timeout_cycles != 32'd0) &&
                    (r_wd == (timeout_cycles - 32'd1));

  // WAIT_OUT is left on the first cycle receiving is seen high, so any high
  // sample there is either a true 0->1 transition or a level that was
  // already high on entry; both count as the start of capture.
  assign w_rise = out_receiving;

  // In CAPTURE the previous sample is always high, so this is the 1->0 edge.
  assign w_fall = r_rx_prev && !out_receiving;

  // DONE/ERROR side effects are suppressed when abort lands in that cycle.
  assign w_done_set = (r_state == c_done)  && !abort;
  assign w_err_set  = (r_state == c_error) && !abort;

  // --------------------------------------------------------------------------
  // Next-state logic. Watchdog expiry takes precedence over the normal exit
  // of a state, and abort overrides everything.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_idle: begin
        if (start) w_next = c_load;
      end
      c_load: begin
        if (w_wd_hit)          w_next = c_error;
        else if (in_load_done) w_next = c_wait_out;
      end
      c_wait_out: begin
        if (w_wd_hit)    w_next = c_error;
        else if (w_rise) w_next = c_capture;
      end
      c_capture: begin
        if (w_wd_hit)    w_next = c_error;
        else if (w_fall) w_next = c_done;
      end
      c_done:  w_next = c_idle;
      c_error: w_next = c_idle;
      default: w_next = c_idle;
    endcase
    if (w_abort) w_next = c_idle;
  end

  // --------------------------------------------------------------------------
  // State, watchdog and capture-length bookkeeping.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= c_idle;
      r_rx_prev <= 1'b0;
      r_len     <= '0;
      r_wd      <= 32'd0;
    end else begin
      r_state   <= w_next;
      r_rx_prev <= out_receiving;

      // Watchdog restarts on every state change so the limit applies to
      // each supervised phase individually.
      if (w_next != r_state) begin
        r_wd <= 32'd0;
      end else if ((r_state == c_load) || (r_state == c_wait_out) ||
                   (r_state == c_capture)) begin
        r_wd <= r_wd + 32'd1;
      end else begin
        r_wd <= 32'd0;
      end

      // The rise cycle itself is the first counted receiving cycle.
      if ((r_state == c_wait_out) && (w_next == c_capture)) begin
        r_len <= {{(LEN_W-1){1'b0}}, 1'b1};
      end else if ((r_state == c_capture) && out_receiving &&
                   (r_len != c_len_max)) begin
        r_len <= r_len + {{(LEN_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // --------------------------------------------------------------------------
  // Host-visible flags, pulses and frame counter.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      in_load_start <= 1'b0;
      done          <= 1'b0;
      irq           <= 1'b0;
      err_timeout   <= 1'b0;
      err_len       <= 1'b0;
      frame_count   <= '0;
    end else begin
      // Lands in the first LOAD cycle.
      in_load_start <= w_accept;
      irq           <= w_done_set || w_err_set;

      // Setting done beats a simultaneous ack.
      if (w_done_set) begin
        done <= 1'b1;
      end else if (ack || w_accept) begin
        done <= 1'b0;
      end

      if (w_accept) begin
        err_timeout <= 1'b0;
      end else if (w_err_set) begin
        err_timeout <= 1'b1;
      end

      if (w_accept) begin
        err_len <= 1'b0;
      end else if (w_done_set && (r_len != c_len_nfft)) begin
        err_len <= 1'b1;
      end

      if (w_done_set) begin
        frame_count <= frame_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign busy     = (r_state != c_idle);
  assign buf_lock = (r_state == c_wait_out) || (r_state == c_capture);

endmodule
`default_nettype wire
